event_counter_bank: RTL and testbench

Parametrised bank of NUM_CH independent event counters, each WIDTH bits wide. This is the next generation of the team's single-bit conditional counter. Each channel adds per-channel enable, up/down direction, synchronous clear and load, wrap or saturate mode, a one-cycle terminal-count pulse and a sticky overflow flag. Used as a generic event/statistics counter inside demo SoC peripherals.

---
 rtl/event_counter_bank.sv | 108 ++++++++++
 tb/tb_event_counter_bank.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/event_counter_bank.sv
// event_counter_bank
//   Bank of NUM_CH independent WIDTH-bit event counters. Each channel has
//   its own enable, up/down direction, synchronous clear and load, a
//   one-cycle terminal-count pulse and a sticky overflow flag. SATURATE
//   selects wrap-around (0) or hold-at-limit (1) behaviour.
//
// Ports
//   clk_i       system clock, rising edge
//   reset_ni    asynchronous active-low reset
//   cnt_en_i    per-channel count enable
//   dir_i       per-channel direction, 1 = up, 0 = down
//   clr_i       per-channel synchronous clear to INIT_VAL (also clears ovf)
//   load_i      per-channel synchronous load from load_val_i
//   load_val_i  load values, channel n in [n*WIDTH +: WIDTH]
//   cnt_o       registered counter values, same packing as load_val_i
//   tc_o        registered one-cycle terminal-count pulse per channel
//   ovf_o       registered sticky overflow/underflow flag per channel
//   active_o    combinational OR of cnt_en_i
module event_counter_bank #(
   parameter int unsigned      NUM_CH   = 4,
   parameter int unsigned      WIDTH    = 8,
   parameter int unsigned      SATURATE = 0,
   parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
   input  logic                    clk_i,
   input  logic                    reset_ni,
   input  logic [NUM_CH-1:0]       cnt_en_i,
   input  logic [NUM_CH-1:0]       dir_i,
   input  logic [NUM_CH-1:0]       clr_i,
   input  logic [NUM_CH-1:0]       load_i,
   input  logic [NUM_CH*WIDTH-1:0] load_val_i,
   output logic [NUM_CH*WIDTH-1:0] cnt_o,
   output logic [NUM_CH-1:0]       tc_o,
   output logic [NUM_CH-1:0]       ovf_o,
   output logic                    active_o
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   assign active_o = |cnt_en_i;

   for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
      logic [WIDTH-1:0] cnt_q, cnt_d, cnt_inc, cnt_dec;
      logic             tc_q, tc_d;
      logic             ovf_q, ovf_d;
      logic             pin_q, pin_d;
      logic             at_limit;

      assign cnt_inc  = cnt_q + ONE;
      assign cnt_dec  = cnt_q - ONE;
      assign at_limit = dir_i[n] ? (cnt_q == '1) : (cnt_q == '0);

      // Saturating mode: pin_q marks a counter that has already reported
      // its arrival at the current limit (by stepping onto it or by a first
      // attempt past it). While pinned, further attempts past the limit
      // set ovf but stay silent on tc. Clear, load or a step away unpins.
      always_comb begin
         cnt_d = cnt_q;
         tc_d  = 1'b0;
         ovf_d = ovf_q;
         pin_d = pin_q;
         if (clr_i[n]) begin
            cnt_d = INIT_VAL;
            ovf_d = 1'b0;
            pin_d = 1'b0;
         end else if (load_i[n]) begin
            cnt_d = load_val_i[n*WIDTH +: WIDTH];
            pin_d = 1'b0;
         end else if (cnt_en_i[n]) begin
            if (at_limit) begin
               ovf_d = 1'b1;
               if (SATURATE != 0) begin
                  tc_d  = ~pin_q;
                  pin_d = 1'b1;
               end else begin
                  cnt_d = dir_i[n] ? '0 : '1;
                  tc_d  = 1'b1;
               end
            end else begin
               cnt_d = dir_i[n] ? cnt_inc : cnt_dec;
               if (SATURATE != 0) begin
                  tc_d  = dir_i[n] ? (cnt_inc == '1) : (cnt_dec == '0);
                  pin_d = tc_d;
               end
            end
         end
      end

      always_ff @(posedge clk_i or negedge reset_ni) begin
         if (!reset_ni) begin
            cnt_q <= INIT_VAL;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
            pin_q <= 1'b0;
         end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
            pin_q <= pin_d;
         end
      end

      assign cnt_o[n*WIDTH +: WIDTH] = cnt_q;
      assign tc_o[n]                 = tc_q;
      assign ovf_o[n]                = ovf_q;
   end

endmodule

// File: tb/tb_event_counter_bank.sv
module tb_event_counter_bank;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] en, dir, clr, load;
   logic [7:0] load_val;
   logic [7:0] cnt_w, cnt_s;
   logic [1:0] tc_w, ovf_w, tc_s, ovf_s;
   logic       act_w, act_s;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   event_counter_bank #(.NUM_CH(2), .WIDTH(4), .SATURATE(0), .INIT_VAL(4'd0)) dut_wrap (
      .clk_i(clk), .reset_ni(rst_n), .cnt_en_i(en), .dir_i(dir), .clr_i(clr),
      .load_i(load), .load_val_i(load_val), .cnt_o(cnt_w), .tc_o(tc_w),
      .ovf_o(ovf_w), .active_o(act_w));

   event_counter_bank #(.NUM_CH(2), .WIDTH(4), .SATURATE(1), .INIT_VAL(4'd0)) dut_sat (
      .clk_i(clk), .reset_ni(rst_n), .cnt_en_i(en), .dir_i(dir), .clr_i(clr),
      .load_i(load), .load_val_i(load_val), .cnt_o(cnt_s), .tc_o(tc_s),
      .ovf_o(ovf_s), .active_o(act_s));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_all();
      en = 2'b00; load = 2'b00; clr = 2'b11;
      tick();
      clr = 2'b00;
   endtask

   task automatic test_reset();
      checks++;
      if (cnt_w !== 8'h00 || tc_w !== 2'b00 || ovf_w !== 2'b00) begin
         failures++;
         $display("FAIL reset_wrap cnt=%h tc=%b ovf=%b required 00/00/00", cnt_w, tc_w, ovf_w);
      end
      checks++;
      if (cnt_s !== 8'h00 || tc_s !== 2'b00 || ovf_s !== 2'b00) begin
         failures++;
         $display("FAIL reset_sat cnt=%h tc=%b ovf=%b required 00/00/00", cnt_s, tc_s, ovf_s);
      end
      en = 2'b01;
      #1;
      checks++;
      if (act_w !== 1'b1) begin
         failures++;
         $display("FAIL active_in_reset got %b required 1", act_w);
      end
      @(negedge clk);
      rst_n = 1'b1;
      dir = 2'b01;
      repeat (5) tick();
      checks++;
      if (cnt_w[3:0] !== 4'd5) begin
         failures++;
         $display("FAIL pre_reset_count got %0d required 5", cnt_w[3:0]);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (cnt_w !== 8'h00 || tc_w !== 2'b00 || ovf_w !== 2'b00) begin
         failures++;
         $display("FAIL async_reset cnt=%h tc=%b ovf=%b required 00/00/00", cnt_w, tc_w, ovf_w);
      end
      #2 rst_n = 1'b1;
      tick();
      checks++;
      if (cnt_w[3:0] !== 4'd1) begin
         failures++;
         $display("FAIL resume_after_reset got %0d required 1", cnt_w[3:0]);
      end
   endtask

   task automatic test_wrap_up();
      logic [3:0] exp_w, exp_s;
      clear_all();
      en = 2'b01; dir = 2'b01;
      for (int i = 1; i <= 16; i++) begin
         tick();
         exp_w = 4'(i % 16);
         exp_s = (i < 15) ? 4'(i) : 4'd15;
         checks++;
         if (cnt_w[3:0] !== exp_w || tc_w[0] !== (i == 16) || ovf_w[0] !== (i == 16)) begin
            failures++;
            $display("FAIL wrap_up step %0d cnt=%0d tc=%b ovf=%b required %0d/%b/%b",
                     i, cnt_w[3:0], tc_w[0], ovf_w[0], exp_w, (i == 16), (i == 16));
         end
         checks++;
         if (cnt_w[7:4] !== 4'd0 || tc_w[1] !== 1'b0) begin
            failures++;
            $display("FAIL idle_ch1 step %0d cnt=%0d tc=%b required 0/0", i, cnt_w[7:4], tc_w[1]);
         end
         checks++;
         if (cnt_s[3:0] !== exp_s || tc_s[0] !== (i == 15) || ovf_s[0] !== (i == 16)) begin
            failures++;
            $display("FAIL sat_up step %0d cnt=%0d tc=%b ovf=%b required %0d/%b/%b",
                     i, cnt_s[3:0], tc_s[0], ovf_s[0], exp_s, (i == 15), (i == 16));
         end
      end
      en = 2'b00;
      tick();
      checks++;
      if (tc_w[0] !== 1'b0 || ovf_w[0] !== 1'b1 || cnt_w[3:0] !== 4'd0) begin
         failures++;
         $display("FAIL ovf_sticky cnt=%0d tc=%b ovf=%b required 0/0/1", cnt_w[3:0], tc_w[0], ovf_w[0]);
      end
   endtask

   task automatic test_wrap_down_clear();
      clear_all();
      en = 2'b10; dir = 2'b00;
      tick();
      checks++;
      if (cnt_w[7:4] !== 4'd15 || tc_w[1] !== 1'b1 || ovf_w[1] !== 1'b1) begin
         failures++;
         $display("FAIL wrap_down cnt=%0d tc=%b ovf=%b required 15/1/1", cnt_w[7:4], tc_w[1], ovf_w[1]);
      end
      checks++;
      if (cnt_s[7:4] !== 4'd0 || tc_s[1] !== 1'b1 || ovf_s[1] !== 1'b1) begin
         failures++;
         $display("FAIL sat_down_first cnt=%0d tc=%b ovf=%b required 0/1/1", cnt_s[7:4], tc_s[1], ovf_s[1]);
      end
      tick();
      checks++;
      if (cnt_w[7:4] !== 4'd14 || tc_w[1] !== 1'b0 || ovf_w[1] !== 1'b1) begin
         failures++;
         $display("FAIL down_after_wrap cnt=%0d tc=%b ovf=%b required 14/0/1", cnt_w[7:4], tc_w[1], ovf_w[1]);
      end
      checks++;
      if (cnt_s[7:4] !== 4'd0 || tc_s[1] !== 1'b0 || ovf_s[1] !== 1'b1) begin
         failures++;
         $display("FAIL sat_down_held cnt=%0d tc=%b ovf=%b required 0/0/1", cnt_s[7:4], tc_s[1], ovf_s[1]);
      end
      en = 2'b00; clr = 2'b10;
      tick();
      checks++;
      if (cnt_w[7:4] !== 4'd0 || tc_w[1] !== 1'b0 || ovf_w[1] !== 1'b0) begin
         failures++;
         $display("FAIL clear cnt=%0d tc=%b ovf=%b required 0/0/0", cnt_w[7:4], tc_w[1], ovf_w[1]);
      end
      en = 2'b10; dir = 2'b00; clr = 2'b10;
      tick();
      checks++;
      if (cnt_w[7:4] !== 4'd0 || tc_w[1] !== 1'b0 || ovf_w[1] !== 1'b0) begin
         failures++;
         $display("FAIL clear_vs_limit cnt=%0d tc=%b ovf=%b required 0/0/0", cnt_w[7:4], tc_w[1], ovf_w[1]);
      end
      clr = 2'b00; en = 2'b00;
   endtask

   task automatic test_saturate();
      logic exp_tc;
      clear_all();
      load = 2'b01; load_val = 8'h0E;
      tick();
      load = 2'b00;
      checks++;
      if (cnt_s[3:0] !== 4'd14 || tc_s[0] !== 1'b0) begin
         failures++;
         $display("FAIL sat_load cnt=%0d tc=%b required 14/0", cnt_s[3:0], tc_s[0]);
      end
      en = 2'b01; dir = 2'b01;
      for (int i = 0; i < 4; i++) begin
         tick();
         exp_tc = (i == 0);
         checks++;
         if (cnt_s[3:0] !== 4'd15 || tc_s[0] !== exp_tc || ovf_s[0] !== (i > 0)) begin
            failures++;
            $display("FAIL sat_hold_up step %0d cnt=%0d tc=%b ovf=%b required 15/%b/%b",
                     i, cnt_s[3:0], tc_s[0], ovf_s[0], exp_tc, (i > 0));
         end
      end
      en = 2'b00; clr = 2'b01;
      tick();
      clr = 2'b00; en = 2'b01; dir = 2'b00;
      for (int i = 0; i < 3; i++) begin
         tick();
         exp_tc = (i == 0);
         checks++;
         if (cnt_s[3:0] !== 4'd0 || tc_s[0] !== exp_tc || ovf_s[0] !== 1'b1) begin
            failures++;
            $display("FAIL sat_hold_down step %0d cnt=%0d tc=%b ovf=%b required 0/%b/1",
                     i, cnt_s[3:0], tc_s[0], ovf_s[0], exp_tc);
         end
      end
      en = 2'b00;
   endtask

   task automatic test_priority();
      clear_all();
      load = 2'b01; load_val = 8'h05;
      tick();
      clr = 2'b01; load = 2'b01; load_val = 8'h09; en = 2'b01; dir = 2'b01;
      tick();
      checks++;
      if (cnt_w[3:0] !== 4'd0) begin
         failures++;
         $display("FAIL clr_over_load got %0d required 0", cnt_w[3:0]);
      end
      clr = 2'b00;
      tick();
      checks++;
      if (cnt_w[3:0] !== 4'd9) begin
         failures++;
         $display("FAIL load_over_en got %0d required 9", cnt_w[3:0]);
      end
      en = 2'b00; load_val = 8'h0F;
      tick();
      checks++;
      if (cnt_w[3:0] !== 4'd15 || tc_w[0] !== 1'b0 || ovf_w[0] !== 1'b0) begin
         failures++;
         $display("FAIL load_limit cnt=%0d tc=%b ovf=%b required 15/0/0", cnt_w[3:0], tc_w[0], ovf_w[0]);
      end
      load = 2'b00; en = 2'b01;
      tick();
      checks++;
      if (cnt_w[3:0] !== 4'd0 || tc_w[0] !== 1'b1 || ovf_w[0] !== 1'b1) begin
         failures++;
         $display("FAIL wrap_after_load cnt=%0d tc=%b ovf=%b required 0/1/1", cnt_w[3:0], tc_w[0], ovf_w[0]);
      end
      en = 2'b00; load = 2'b01;
      tick();
      checks++;
      if (cnt_w[3:0] !== 4'd15 || tc_w[0] !== 1'b0 || ovf_w[0] !== 1'b1) begin
         failures++;
         $display("FAIL load_keeps_ovf cnt=%0d tc=%b ovf=%b required 15/0/1", cnt_w[3:0], tc_w[0], ovf_w[0]);
      end
      load = 2'b00;
   endtask

   // Reference model, index [mode][channel], mode 0 = wrap, 1 = saturate.
   logic [3:0] m_cnt [2][2];
   logic       m_tc  [2][2];
   logic       m_ovf [2][2];
   logic       m_pin [2][2];

   task automatic model_step();
      for (int m = 0; m < 2; m++) begin
         for (int c = 0; c < 2; c++) begin
            logic [3:0] v;
            logic       t;
            v = m_cnt[m][c];
            t = 1'b0;
            if (clr[c]) begin
               v = 4'd0; m_ovf[m][c] = 1'b0; m_pin[m][c] = 1'b0;
            end else if (load[c]) begin
               v = load_val[c*4 +: 4]; m_pin[m][c] = 1'b0;
            end else if (en[c]) begin
               if ((dir[c] && v == 4'd15) || (!dir[c] && v == 4'd0)) begin
                  m_ovf[m][c] = 1'b1;
                  if (m == 0) begin
                     v = dir[c] ? 4'd0 : 4'd15;
                     t = 1'b1;
                  end else begin
                     t = !m_pin[m][c];
                     m_pin[m][c] = 1'b1;
                  end
               end else begin
                  v = dir[c] ? v + 4'd1 : v - 4'd1;
                  if (m == 1 && (v == 4'd15 || v == 4'd0)) begin
                     t = 1'b1;
                     m_pin[m][c] = 1'b1;
                  end else begin
                     m_pin[m][c] = 1'b0;
                  end
               end
            end
            m_cnt[m][c] = v;
            m_tc[m][c]  = t;
         end
      end
   endtask

   task automatic test_random();
      int bad = 0;
      clear_all();
      for (int m = 0; m < 2; m++)
         for (int c = 0; c < 2; c++) begin
            m_cnt[m][c] = 4'd0; m_tc[m][c] = 1'b0; m_ovf[m][c] = 1'b0; m_pin[m][c] = 1'b0;
         end
      for (int i = 0; i < 10000; i++) begin
         en       = 2'($urandom_range(0, 3));
         dir      = 2'($urandom_range(0, 3));
         clr      = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)};
         load     = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
         load_val = 8'($urandom_range(0, 255));
         #1;
         checks++;
         if (act_w !== (en != 2'b00) || act_s !== (en != 2'b00)) begin
            failures++;
            bad++;
            if (bad < 10) $display("FAIL active cycle %0d got %b/%b en=%b", i, act_w, act_s, en);
         end
         model_step();
         tick();
         checks++;
         if (cnt_w !== {m_cnt[0][1], m_cnt[0][0]} || tc_w !== {m_tc[0][1], m_tc[0][0]} ||
             ovf_w !== {m_ovf[0][1], m_ovf[0][0]}) begin
            failures++;
            bad++;
            if (bad < 10)
               $display("FAIL random_wrap cycle %0d cnt=%h tc=%b ovf=%b required %h/%b/%b", i,
                        cnt_w, tc_w, ovf_w, {m_cnt[0][1], m_cnt[0][0]},
                        {m_tc[0][1], m_tc[0][0]}, {m_ovf[0][1], m_ovf[0][0]});
         end
         checks++;
         if (cnt_s !== {m_cnt[1][1], m_cnt[1][0]} || tc_s !== {m_tc[1][1], m_tc[1][0]} ||
             ovf_s !== {m_ovf[1][1], m_ovf[1][0]}) begin
            failures++;
            bad++;
            if (bad < 10)
               $display("FAIL random_sat cycle %0d cnt=%h tc=%b ovf=%b required %h/%b/%b", i,
                        cnt_s, tc_s, ovf_s, {m_cnt[1][1], m_cnt[1][0]},
                        {m_tc[1][1], m_tc[1][0]}, {m_ovf[1][1], m_ovf[1][0]});
         end
      end
      en = 2'b00; clr = 2'b00; load = 2'b00;
   endtask

   initial begin
      rst_n = 1'b0;
      en = 2'b00; dir = 2'b00; clr = 2'b00; load = 2'b00; load_val = 8'h00;
      #12;
      test_reset();
      test_wrap_up();
      test_wrap_down_clear();
      test_saturate();
      test_priority();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
